fetch_decode: RTL and testbench

- Front-end stage of the PAF core, directly upstream of the register bench and ALU.
- Owns the program counter and the instruction register.
- Fetches 32-bit words from instruction memory over a req/valid handshake.
- Decodes the held instruction into type_inst, opcode, Rs1, Rs2, Rd and imm, which drive the bench and the ALU.
- PC updates are driven by the existing controller strobes: enable_PC, load_new_PC, sel_inc, link, enable_I.

---
 rtl/paf_pkg.sv | 47 ++++
 rtl/fetch_decode_decoder.sv | 42 ++++
 rtl/fetch_decode.sv | 135 +++++++++++++
 tb/tb_fetch_decode.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paf_pkg.sv
// PAF core front-end shared types.
// Instruction classes, fetch FSM states and field positions.
package paf_pkg;

  typedef enum logic [1:0] {
    TYPE_R = 2'b00,
    TYPE_J = 2'b01,
    TYPE_B = 2'b10,
    TYPE_I = 2'b11
  } inst_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;
  localparam int OP_HI   = 29;
  localparam int OP_LO   = 24;
  localparam int RS1_HI  = 23;
  localparam int RS1_LO  = 18;
  localparam int F2_HI   = 17;
  localparam int F2_LO   = 12;
  localparam int F3_HI   = 11;
  localparam int F3_LO   = 6;
  localparam int IMM12_HI = 11;
  localparam int IMM16_HI = 15;

  typedef struct packed {
    logic [1:0]  type_inst;
    logic [5:0]  opcode;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [15:0] imm;
  } dec_t;

  function automatic logic [15:0] sext12(
    input logic [11:0] v
  );
    return {{4{v[11]}}, v};
  endfunction

endpackage

// File: rtl/fetch_decode_decoder.sv
// Pure combinational IR -> field decoder.
// Shared by the front-end and offline disassembly.
module instr_decoder
  import paf_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [1:0] t;

  assign t = ir[TYPE_HI:TYPE_LO];

  always_comb begin
    dec           = '0;
    dec.type_inst = t;
    dec.opcode    = ir[OP_HI:OP_LO];
    dec.rs1       = ir[RS1_HI:RS1_LO];
    unique case (1'b1)
      t == TYPE_R: begin
        dec.rs2 = ir[F2_HI:F2_LO];
        dec.rd  = ir[F3_HI:F3_LO];
      end
      t == TYPE_I: begin
        dec.rd  = ir[F2_HI:F2_LO];
        dec.imm = sext12(ir[IMM12_HI:0]);
      end
      t == TYPE_B: begin
        dec.rs2 = ir[F2_HI:F2_LO];
        dec.imm = sext12(ir[IMM12_HI:0]);
      end
      t == TYPE_J: begin
        // jumps reuse the Rs1 slot as the destination
        dec.rd  = ir[RS1_HI:RS1_LO];
        dec.rs1 = '0;
        dec.imm = ir[IMM16_HI:0];
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// PAF front-end: PC, instruction fetch FSM and IR decode.
// Feeds the register bench and ALU with decoded fields.
module fetch_decode
  import paf_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_I,
  input  logic            enable_PC,
  input  logic            load_new_PC,
  input  logic            sel_inc,
  input  logic            condition,
  input  logic            link,
  input  logic [31:0]     Rs1_val,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     link_addr,
  output logic            instr_valid,
  output logic [1:0]      type_inst,
  output logic [5:0]      opcode,
  output logic [5:0]      Rs1,
  output logic [5:0]      Rs2,
  output logic [5:0]      Rd,
  output logic [15:0]     imm
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [31:0]     ir_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] addr_q;
  logic [31:0]     link_q;
  logic            fetch_go;
  logic            ir_ld;
  dec_t            dec;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_imm;
  logic [PC_W-1:0] imm_pc;
  logic            take_imm;
  logic [31:0]     unused_rs1;

  assign unused_rs1 = Rs1_val;

  instr_decoder u_dec (
    .ir  (ir_q),
    .dec (dec)
  );

  always_comb begin
    state_d  = state_q;
    fetch_go = 1'b0;
    ir_ld    = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (enable_I) begin
          state_d  = S_REQ;
          fetch_go = 1'b1;
        end
      end
      S_REQ, S_WAIT: begin
        if (imem_valid) begin
          state_d = S_HOLD;
          ir_ld   = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // offset is sign-extended or truncated to the PC width
  assign imm_pc   = PC_W'($signed(dec.imm));
  assign pc_inc   = pc_q + PC_W'(1);
  assign pc_imm   = pc_q + imm_pc;
  assign take_imm = sel_inc &&
                    (dec.type_inst != TYPE_B || condition);

  always_comb begin
    pc_d = pc_q;
    if (enable_PC) begin
      if (load_new_PC) begin
        pc_d = Rs1_val[PC_W-1:0];
      end else if (take_imm) begin
        pc_d = pc_imm;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (fetch_go) begin
        addr_q <= pc_q;
      end
      if (ir_ld) begin
        ir_q <= imem_rdata;
      end
      if (enable_PC && link) begin
        link_q <= 32'(pc_inc);
      end
    end
  end

  assign imem_req    = (state_q == S_REQ) ||
                       (state_q == S_WAIT);
  assign instr_valid = (state_q == S_HOLD);
  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign link_addr   = link_q;
  assign type_inst   = dec.type_inst;
  assign opcode      = dec.opcode;
  assign Rs1         = dec.rs1;
  assign Rs2         = dec.rs2;
  assign Rd          = dec.rd;
  assign imm         = dec.imm;

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode.
// Directed vectors plus randomized traffic against a reference model.
module tb_fetch_decode;

  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable_I;
  logic            enable_PC;
  logic            load_new_PC;
  logic            sel_inc;
  logic            condition;
  logic            link;
  logic [31:0]     Rs1_val;
  logic [31:0]     imem_rdata;
  logic            imem_valid;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [PC_W-1:0] pc;
  logic [31:0]     link_addr;
  logic            instr_valid;
  logic [1:0]      type_inst;
  logic [5:0]      opcode;
  logic [5:0]      Rs1;
  logic [5:0]      Rs2;
  logic [5:0]      Rd;
  logic [15:0]     imm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_decode #(
    .PC_W     (PC_W),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_I    (enable_I),
    .enable_PC   (enable_PC),
    .load_new_PC (load_new_PC),
    .sel_inc     (sel_inc),
    .condition   (condition),
    .link        (link),
    .Rs1_val     (Rs1_val),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .link_addr   (link_addr),
    .instr_valid (instr_valid),
    .type_inst   (type_inst),
    .opcode      (opcode),
    .Rs1         (Rs1),
    .Rs2         (Rs2),
    .Rd          (Rd),
    .imm         (imm)
  );

  typedef struct {
    logic [1:0]  t;
    logic [5:0]  op;
    logic [5:0]  r1;
    logic [5:0]  r2;
    logic [5:0]  rd;
    logic [15:0] im;
  } fields_t;

  typedef struct {
    logic [31:0] w;
    logic [1:0]  t;
    logic [5:0]  op;
    logic [5:0]  r1;
    logic [5:0]  r2;
    logic [5:0]  rd;
    logic [15:0] im;
  } vec_t;

  // reference model state: plain integers and flags
  int          m_pc;
  int          m_addr;
  int          m_link;
  logic [31:0] m_ir;
  bit          m_busy;
  bit          m_hold;

  function automatic int wrap(input int v);
    return ((v % 65536) + 65536) % 65536;
  endfunction

  function automatic fields_t ref_dec(input logic [31:0] w);
    fields_t f;
    f.t  = w[31:30];
    f.op = w[29:24];
    f.r1 = w[23:18];
    f.r2 = '0;
    f.rd = '0;
    f.im = '0;
    case (f.t)
      2'b00: begin
        f.r2 = w[17:12];
        f.rd = w[11:6];
      end
      2'b11: begin
        f.rd = w[17:12];
        f.im = {{4{w[11]}}, w[11:0]};
      end
      2'b10: begin
        f.r2 = w[17:12];
        f.im = {{4{w[11]}}, w[11:0]};
      end
      default: begin
        f.rd = w[23:18];
        f.r1 = '0;
        f.im = w[15:0];
      end
    endcase
    return f;
  endfunction

  function automatic void model_step();
    fields_t f;
    int      old_pc;
    f      = ref_dec(m_ir);
    old_pc = m_pc;
    if (reset) begin
      m_pc   = 0;
      m_addr = 0;
      m_link = 0;
      m_ir   = '0;
      m_busy = 0;
      m_hold = 0;
      return;
    end
    if (!m_busy && enable_I) begin
      m_busy = 1;
      m_hold = 0;
      m_addr = old_pc;
    end else if (m_busy && imem_valid) begin
      m_ir   = imem_rdata;
      m_busy = 0;
      m_hold = 1;
    end
    if (enable_PC) begin
      if (load_new_PC)
        m_pc = int'(Rs1_val & 32'h0000_FFFF);
      else if (sel_inc && (f.t != 2'b10 || condition))
        m_pc = wrap(old_pc + int'($signed(f.im)));
      else
        m_pc = wrap(old_pc + 1);
      if (link)
        m_link = wrap(old_pc + 1);
    end
  endfunction

  task automatic check_all(input string tag);
    fields_t      f;
    logic [107:0] act;
    logic [107:0] exp;
    f   = ref_dec(m_ir);
    act = {imem_req, imem_addr, pc, link_addr,
           instr_valid, type_inst, opcode,
           Rs1, Rs2, Rd, imm};
    exp = {m_busy, 16'(m_addr), 16'(m_pc),
           32'(m_link), m_hold, f.t, f.op,
           f.r1, f.r2, f.rd, f.im};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model_%s got %h want %h",
               tag, act, exp);
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    reset       = 1'b0;
    enable_I    = 1'b0;
    enable_PC   = 1'b0;
    load_new_PC = 1'b0;
    sel_inc     = 1'b0;
    condition   = 1'b0;
    link        = 1'b0;
    Rs1_val     = '0;
    imem_rdata  = '0;
    imem_valid  = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    idle();
    enable_PC   = 1'b1;
    load_new_PC = 1'b1;
    Rs1_val     = v;
    cyc("set_pc");
    idle();
  endtask

  task automatic fetch(input logic [31:0] w,
                       input int lat);
    idle();
    enable_I = 1'b1;
    cyc("fetch_go");
    chk("valid_drop", 32'(instr_valid), 0);
    enable_I = 1'b0;
    repeat (lat) cyc("fetch_wait");
    imem_valid = 1'b1;
    imem_rdata = w;
    cyc("fetch_rsp");
    idle();
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{32'hC804_3005, 2'b11, 6'h08,
              6'h01, 6'h00, 6'h03, 16'h0005};
    vt[1] = '{{2'b11, 6'h3F, 6'h3F, 6'h2A, 12'hFFF},
              2'b11, 6'h3F, 6'h3F, 6'h00, 6'h2A,
              16'hFFFF};
    vt[2] = '{{2'b00, 6'h15, 6'h07, 6'h12,
               6'h21, 6'h3F},
              2'b00, 6'h15, 6'h07, 6'h12, 6'h21,
              16'h0000};
    vt[3] = '{{2'b10, 6'h02, 6'h05, 6'h06, 12'hFFC},
              2'b10, 6'h02, 6'h05, 6'h06, 6'h00,
              16'hFFFC};
    vt[4] = '{{2'b10, 6'h01, 6'h03, 6'h04, 12'h7FF},
              2'b10, 6'h01, 6'h03, 6'h04, 6'h00,
              16'h07FF};
    vt[5] = '{{2'b01, 6'h10, 6'h0B, 2'b11, 16'h8001},
              2'b01, 6'h10, 6'h00, 6'h00, 6'h0B,
              16'h8001};

    m_pc = 0; m_addr = 0; m_link = 0;
    m_ir = '0; m_busy = 0; m_hold = 0;

    idle();
    reset = 1'b1;
    cyc("reset");
    cyc("reset");
    idle();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_link", link_addr, 0);
    chk("rst_fields",
        {type_inst, opcode, Rs1, Rs2, Rd}, 0);

    // first fetch, response on the third request cycle
    enable_I = 1'b1;
    cyc("tp_go");
    enable_I = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tp_req%0d", i), 32'(imem_req), 1);
      chk($sformatf("tp_addr%0d", i),
          32'(imem_addr), 0);
      imem_valid = (i == 2);
      imem_rdata = 32'hC804_3005;
      cyc("tp_wait");
    end
    idle();
    chk("tp_valid", 32'(instr_valid), 1);
    chk("tp_type", 32'(type_inst), 3);
    chk("tp_op", 32'(opcode), 8);
    chk("tp_rs1", 32'(Rs1), 1);
    chk("tp_rd", 32'(Rd), 3);
    chk("tp_imm", 32'(imm), 5);

    enable_PC = 1'b1;
    repeat (3) cyc("seq_inc");
    idle();
    chk("seq_pc", 32'(pc), 3);
    enable_I = 1'b1;
    cyc("seq_fetch");
    chk("seq_addr", 32'(imem_addr), 3);
    idle();
    imem_valid = 1'b1;
    imem_rdata = {2'b10, 6'h02, 6'h05, 6'h06, 12'hFFC};
    cyc("seq_rsp");
    idle();

    set_pc(10);
    enable_PC = 1'b1;
    sel_inc   = 1'b1;
    condition = 1'b1;
    cyc("br_taken");
    chk("br_taken_pc", 32'(pc), 6);
    set_pc(10);
    enable_PC = 1'b1;
    sel_inc   = 1'b1;
    condition = 1'b0;
    cyc("br_not");
    chk("br_not_pc", 32'(pc), 11);

    set_pc(7);
    enable_PC   = 1'b1;
    load_new_PC = 1'b1;
    link        = 1'b1;
    Rs1_val     = 32'h0000_0040;
    cyc("jlink");
    chk("jlink_pc", 32'(pc), 64);
    chk("jlink_link", link_addr, 8);
    idle();
    link = 1'b1;
    cyc("link_only");
    chk("link_ignored", link_addr, 8);

    set_pc(32'h0000_FFFF);
    enable_PC = 1'b1;
    cyc("wrap");
    chk("wrap_pc", 32'(pc), 0);
    set_pc(2);
    enable_PC = 1'b1;
    sel_inc   = 1'b1;
    condition = 1'b1;
    cyc("neg_wrap");
    chk("neg_wrap_pc", 32'(pc), 32'hFFFE);

    set_pc(32'h20);
    enable_I  = 1'b1;
    enable_PC = 1'b1;
    cyc("same_cyc");
    chk("same_addr", 32'(imem_addr), 32'h20);
    chk("same_pc", 32'(pc), 32'h21);
    idle();
    imem_valid = 1'b1;
    imem_rdata = 32'hC804_3005;
    cyc("same_rsp");
    idle();

    enable_I = 1'b1;
    cyc("mw_go");
    idle();
    cyc("mw_wait");
    chk("mw_req", 32'(imem_req), 1);
    reset = 1'b1;
    cyc("mw_reset");
    idle();
    chk("mw_req_rst", 32'(imem_req), 0);
    chk("mw_valid_rst", 32'(instr_valid), 0);
    chk("mw_ir_rst", {type_inst, opcode, imm}, 0);
    chk("mw_pc_rst", 32'(pc), 0);
    imem_valid = 1'b1;
    imem_rdata = 32'hC804_3005;
    cyc("mw_late");
    idle();
    chk("mw_late_valid", 32'(instr_valid), 0);
    chk("mw_late_op", 32'(opcode), 0);
    chk("mw_late_req", 32'(imem_req), 0);

    for (int i = 0; i < 6; i++) begin
      fetch(vt[i].w, i % 3);
      chk($sformatf("v%0d_valid", i),
          32'(instr_valid), 1);
      chk($sformatf("v%0d_type", i),
          32'(type_inst), 32'(vt[i].t));
      chk($sformatf("v%0d_op", i),
          32'(opcode), 32'(vt[i].op));
      chk($sformatf("v%0d_rs1", i),
          32'(Rs1), 32'(vt[i].r1));
      chk($sformatf("v%0d_rs2", i),
          32'(Rs2), 32'(vt[i].r2));
      chk($sformatf("v%0d_rd", i),
          32'(Rd), 32'(vt[i].rd));
      chk($sformatf("v%0d_imm", i),
          32'(imm), 32'(vt[i].im));
    end

    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(99) == 0);
      enable_I    = ($urandom_range(3) == 0);
      enable_PC   = ($urandom_range(2) == 0);
      load_new_PC = ($urandom_range(3) == 0);
      sel_inc     = 1'($urandom);
      condition   = 1'($urandom);
      link        = 1'($urandom);
      Rs1_val     = $urandom;
      imem_valid  = 1'($urandom);
      imem_rdata  = $urandom;
      cyc("rand");
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
